// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder: edge-timed FSM recovering the 16-bit address and the
// data/inverse-data word, with a one-cycle strobe for each frame that passes the byte check.
module ir_nec_decoder #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        iIR,
  output logic [15:0] irAddr,
  output logic [15:0] irData,
  output logic        Get_Flag
);

  function automatic longint us2cyc(input longint us);
    return (us * longint'(CLK_HZ)) / 64'd1_000_000;
  endfunction

  localparam int CNT_W = $clog2(us2cyc(10_000) + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LL_MIN  = cnt_t'(us2cyc(8_500));
  localparam cnt_t LL_MAX  = cnt_t'(us2cyc(9_500));
  localparam cnt_t LH_MIN  = cnt_t'(us2cyc(4_000));
  localparam cnt_t LH_MAX  = cnt_t'(us2cyc(5_000));
  localparam cnt_t SH_MIN  = cnt_t'(us2cyc(400));
  localparam cnt_t SH_MAX  = cnt_t'(us2cyc(700));
  localparam cnt_t B1_MIN  = cnt_t'(us2cyc(1_500));
  localparam cnt_t B1_MAX  = cnt_t'(us2cyc(1_900));
  localparam cnt_t FIN_TO  = cnt_t'(us2cyc(2_500));

  typedef enum logic [2:0] {
    IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  cnt_t        cnt_q, cnt_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic [31:0] sreg_q, sreg_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        flag_q, flag_d;

  logic rise, fall, edge_any;
  logic short_ok, one_ok, last_bit, fin_to, shift_en, shift_bit, accept;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value
  assign rise     = sync_q[1] & ~sync_q[2];
  assign fall     = ~sync_q[1] & sync_q[2];
  assign edge_any = rise | fall;

  assign short_ok  = (cnt_q >= SH_MIN) && (cnt_q <= SH_MAX);
  assign one_ok    = (cnt_q >= B1_MIN) && (cnt_q <= B1_MAX);
  assign last_bit  = (bcnt_q == 5'd31);
  assign fin_to    = last_bit && !edge_any && (cnt_q >= FIN_TO);
  assign shift_en  = (state_q == BIT_HIGH) && ((fall && (short_ok || one_ok)) || fin_to);
  // Without a stop burst the last bit is forced to ~data[7], which sits at bit 24 after 31 shifts
  assign shift_bit = fall ? one_ok : ~sreg_q[24];
  assign accept    = (sreg_q[31:24] == ~sreg_q[23:16]);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      sreg_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      sreg_q  <= sreg_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (fall) state_d = LEAD_LOW;
      LEAD_LOW: begin
        if (rise) state_d = (cnt_q >= LL_MIN && cnt_q <= LL_MAX) ? LEAD_HIGH : IDLE;
        else if (cnt_q > LL_MAX) state_d = IDLE;
      end
      LEAD_HIGH: begin
        if (fall) state_d = (cnt_q >= LH_MIN && cnt_q <= LH_MAX) ? BIT_LOW : IDLE;
        else if (cnt_q > LH_MAX) state_d = IDLE;
      end
      BIT_LOW: begin
        if (rise) state_d = short_ok ? BIT_HIGH : IDLE;
        else if (cnt_q > SH_MAX) state_d = IDLE;
      end
      BIT_HIGH: begin
        if (shift_en) state_d = last_bit ? CHECK : BIT_LOW;
        else if (fall) state_d = IDLE;
        else if (!last_bit && cnt_q > B1_MAX) state_d = IDLE;
      end
      CHECK:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    sync_d = {sync_q[1:0], iIR};
    cnt_d  = edge_any ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
    bcnt_d = bcnt_q;
    sreg_d = sreg_q;
    addr_d = addr_q;
    data_d = data_q;
    flag_d = 1'b0;
    if (state_q == IDLE) begin
      bcnt_d = '0;
      sreg_d = '0;
    end
    if (shift_en) begin
      sreg_d = {shift_bit, sreg_q[31:1]};
      bcnt_d = bcnt_q + 5'd1;
    end
    if (state_q == CHECK && accept) begin
      addr_d = sreg_q[15:0];
      data_d = sreg_q[31:16];
      flag_d = 1'b1;
    end
  end

  assign irAddr   = addr_q;
  assign irData   = data_q;
  assign Get_Flag = flag_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder: hand-built NEC frames at a reduced clock rate
// (CLK_HZ = 100 kHz, so 1 cycle = 10 us) with expected address/data worked out by hand.
module tb_ir_nec_decoder;
  localparam int CLK_HZ = 100_000;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        iIR = 1'b1;
  logic [15:0] irAddr;
  logic [15:0] irData;
  logic        Get_Flag;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int flag_cnt = 0;
  int last_flag_cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  int f0;

  ir_nec_decoder #(.CLK_HZ(CLK_HZ)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .iIR(iIR),
    .irAddr(irAddr), .irData(irData), .Get_Flag(Get_Flag)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) if (Get_Flag === 1'b1) begin
    flag_cnt      <= flag_cnt + 1;
    last_flag_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int us);
    iIR = lvl;
    repeat (int'(longint'(us) * CLK_HZ / 1_000_000)) @(negedge Clk);
  endtask

  // rst_bit >= 0 pulses Rst_n in the middle of that bit's low burst
  task automatic send_frame(input logic [15:0] addr, input logic [7:0] data,
                            input logic [7:0] inv, input bit stop, input int rst_bit);
    logic [31:0] bits;
    bits = {inv, data, addr};
    hold(1'b0, 9000);
    hold(1'b1, 4500);
    for (int i = 0; i < 32; i++) begin
      if (i == rst_bit) begin
        hold(1'b0, 280);
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        hold(1'b0, 280);
      end else begin
        hold(1'b0, 560);
      end
      if (i == 31 && !stop) begin
        rise_cyc = cyc;
        iIR = 1'b1;
      end else begin
        hold(1'b1, bits[i] ? 1690 : 560);
      end
    end
    if (stop) begin
      fall_cyc = cyc;
      hold(1'b0, 560);
      iIR = 1'b1;
    end
  endtask

  initial begin
    @(negedge Clk);
    Rst_n = 1'b0;
    iIR   = 1'b1;
    repeat (10) @(negedge Clk);
    chk("rst_addr", irAddr, 32'h0);
    chk("rst_data", irData, 32'h0);
    chk("rst_flag", flag_cnt, 32'd0);
    Rst_n = 1'b1;
    hold(1'b1, 1000);

    // frame 1, no stop burst
    f0 = flag_cnt;
    send_frame(16'h0001, 8'h12, 8'hED, 1'b0, -1);
    hold(1'b1, 3000);
    chk("f1_flags", flag_cnt - f0, 32'd1);
    chk("f1_addr", irAddr, 32'h0001);
    chk("f1_data", irData, 32'hED12);
    chk("f1_latency", 32'((last_flag_cyc - rise_cyc) >= 250 && (last_flag_cyc - rise_cyc) <= 256), 32'd1);

    // 60 ms gap, then frame 2; previous values held until its strobe
    hold(1'b1, 60000);
    chk("gap_addr", irAddr, 32'h0001);
    chk("gap_data", irData, 32'hED12);
    f0 = flag_cnt;
    send_frame(16'h0002, 8'hEB, 8'h14, 1'b0, -1);
    chk("f2_pre_addr", irAddr, 32'h0001);
    hold(1'b1, 3000);
    chk("f2_flags", flag_cnt - f0, 32'd1);
    chk("f2_addr", irAddr, 32'h0002);
    chk("f2_data", irData, 32'h14EB);

    // bad inverse byte with stop burst
    f0 = flag_cnt;
    send_frame(16'h00FF, 8'h5A, 8'hA4, 1'b1, -1);
    hold(1'b1, 3000);
    chk("bad_flags", flag_cnt - f0, 32'd0);
    chk("bad_addr", irAddr, 32'h0002);
    chk("bad_data", irData, 32'h14EB);

    // repeat code, then valid frame with stop burst
    f0 = flag_cnt;
    hold(1'b0, 9000);
    hold(1'b1, 2250);
    hold(1'b0, 560);
    hold(1'b1, 3000);
    chk("rep_flags", flag_cnt - f0, 32'd0);
    send_frame(16'h8001, 8'h3C, 8'hC3, 1'b1, -1);
    hold(1'b1, 500);
    chk("f3_flags", flag_cnt - f0, 32'd1);
    chk("f3_addr", irAddr, 32'h8001);
    chk("f3_data", irData, 32'hC33C);
    chk("f3_latency", 32'((last_flag_cyc - fall_cyc) >= 2 && (last_flag_cyc - fall_cyc) <= 4), 32'd1);

    // short 5 ms lead, then valid frame
    f0 = flag_cnt;
    hold(1'b0, 5000);
    hold(1'b1, 3000);
    chk("short_flags", flag_cnt - f0, 32'd0);
    send_frame(16'h1234, 8'h00, 8'hFF, 1'b0, -1);
    hold(1'b1, 3000);
    chk("f4_flags", flag_cnt - f0, 32'd1);
    chk("f4_addr", irAddr, 32'h1234);
    chk("f4_data", irData, 32'hFF00);

    // reset pulsed during bit 10 clears outputs, no strobe
    f0 = flag_cnt;
    send_frame(16'h0F0F, 8'h77, 8'h88, 1'b0, 10);
    hold(1'b1, 3000);
    chk("abort_flags", flag_cnt - f0, 32'd0);
    chk("abort_addr", irAddr, 32'h0);
    chk("abort_data", irData, 32'h0);
    send_frame(16'h1234, 8'h00, 8'hFF, 1'b0, -1);
    hold(1'b1, 3000);
    chk("f5_flags", flag_cnt - f0, 32'd1);
    chk("f5_addr", irAddr, 32'h1234);
    chk("f5_data", irData, 32'hFF00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
